// File: rtl/writeback_scoreboard.sv
// writeback_scoreboard
//   Write-side initiator for the 2R/1W register file. Merges single-cycle
//   pipeline results with long-latency (mul/div) results onto the single
//   registered write port. A busy bitmap tracks the destinations of
//   in-flight long-latency ops and raises a decode stall on RAW hazards.
//
// Ports
//   clk, rst                  clock (rising edge), async active-low reset
//   pipe_valid/waddr/wdata    single-cycle result; always accepted, has priority
//   md_issue_valid/waddr      long-latency issue; accepted when md_issue_ready
//   md_issue_ready            !full and destination not already busy (blocks WAW)
//   md_done_valid/wdata       long-latency result, arrives in issue order
//   md_done_ready             result consumed when pipe idle and FIFO non-empty
//   rs_a, rs_b / stall        decode read addresses / hold decode on RAW hazard
//   wen, waddr, wdata         registered register-file write port
//   pending_count             long-latency ops in flight (FIFO occupancy)
//   err                       sticky protocol error, cleared only by reset
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. Ready is combinational from current state and may depend on
// the paired valid/address inputs; valid must not depend on ready.

module writeback_scoreboard #(
  parameter int MD_OUTSTANDING = 4,
  parameter int CNT_W          = $clog2(MD_OUTSTANDING) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pipe_valid,
  input  logic [4:0]       pipe_waddr,
  input  logic [31:0]      pipe_wdata,
  input  logic             md_issue_valid,
  input  logic [4:0]       md_issue_waddr,
  output logic             md_issue_ready,
  input  logic             md_done_valid,
  input  logic [31:0]      md_done_wdata,
  output logic             md_done_ready,
  input  logic [4:0]       rs_a,
  input  logic [4:0]       rs_b,
  output logic             stall,
  output logic             wen,
  output logic [4:0]       waddr,
  output logic [31:0]      wdata,
  output logic [CNT_W-1:0] pending_count,
  output logic             err
);

  localparam int PTR_W = (MD_OUTSTANDING > 1) ? $clog2(MD_OUTSTANDING) : 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(MD_OUTSTANDING);

  // Destination FIFO: issued addresses in issue order; head pairs with the
  // next md_done result.
  logic [4:0]       addr_mem_q [MD_OUTSTANDING];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [31:0]      busy_q, busy_d;
  logic             err_q, err_d;
  logic             wen_q, wen_d;
  logic [4:0]       waddr_q, waddr_d;
  logic [31:0]      wdata_q, wdata_d;

  logic       full, empty, push, pop;
  logic [4:0] head;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign head  = addr_mem_q[rd_ptr_q];

  // Ready uses the current full flag; a same-cycle pop does not make room.
  assign md_issue_ready = !full && !((md_issue_waddr != 5'd0) && busy_q[md_issue_waddr]);
  assign md_done_ready  = !pipe_valid && !empty;

  assign push = md_issue_valid && md_issue_ready;
  assign pop  = md_done_valid && md_done_ready;

  assign stall = ((rs_a != 5'd0) && busy_q[rs_a]) || ((rs_b != 5'd0) && busy_q[rs_b]);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    busy_d   = busy_q;
    err_d    = err_q;
    wen_d    = 1'b0;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;

    // Clear on the edge that registers the md write so busy falls in the
    // same cycle wen is high; forwarding in the register file covers decode.
    // Issue-ready guarantees a set never targets the address being cleared.
    if (pop)  busy_d[head] = 1'b0;
    if (push) busy_d[md_issue_waddr] = 1'b1;
    busy_d[0] = 1'b0;

    if (pipe_valid) begin
      wen_d   = (pipe_waddr != 5'd0);
      waddr_d = pipe_waddr;
      wdata_d = pipe_wdata;
    end else if (pop) begin
      wen_d   = (head != 5'd0);
      waddr_d = head;
      wdata_d = md_done_wdata;
    end

    // Pipe overwriting a register still owed by a long-latency op, or a
    // result with no matching issue, are protocol violations.
    if (pipe_valid && (pipe_waddr != 5'd0) && busy_q[pipe_waddr]) err_d = 1'b1;
    if (md_done_valid && empty) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      busy_q   <= '0;
      err_q    <= 1'b0;
      wen_q    <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
      wen_q    <= wen_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
    end
  end

  // FIFO storage carries no reset; occupancy alone defines validity.
  always_ff @(posedge clk) begin
    if (push) addr_mem_q[wr_ptr_q] <= md_issue_waddr;
  end

  assign wen           = wen_q;
  assign waddr         = waddr_q;
  assign wdata         = wdata_q;
  assign pending_count = count_q;
  assign err           = err_q;

endmodule

// File: tb/tb_writeback_scoreboard.sv
// Directed bench for writeback_scoreboard with hand-computed expectations.
module tb_writeback_scoreboard;

  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             pipe_valid = 1'b0;
  logic [4:0]       pipe_waddr = '0;
  logic [31:0]      pipe_wdata = '0;
  logic             md_issue_valid = 1'b0;
  logic [4:0]       md_issue_waddr = '0;
  logic             md_issue_ready;
  logic             md_done_valid = 1'b0;
  logic [31:0]      md_done_wdata = '0;
  logic             md_done_ready;
  logic [4:0]       rs_a = '0;
  logic [4:0]       rs_b = '0;
  logic             stall;
  logic             wen;
  logic [4:0]       waddr;
  logic [31:0]      wdata;
  logic [CNT_W-1:0] pending_count;
  logic             err;

  int total = 0;
  int bad   = 0;

  // Expected md writes in completion order: {addr, data}
  logic [36:0] exp_q[$];

  writeback_scoreboard #(.MD_OUTSTANDING(4)) dut (
    .clk(clk), .rst(rst),
    .pipe_valid(pipe_valid), .pipe_waddr(pipe_waddr), .pipe_wdata(pipe_wdata),
    .md_issue_valid(md_issue_valid), .md_issue_waddr(md_issue_waddr),
    .md_issue_ready(md_issue_ready),
    .md_done_valid(md_done_valid), .md_done_wdata(md_done_wdata),
    .md_done_ready(md_done_ready),
    .rs_a(rs_a), .rs_b(rs_b), .stall(stall),
    .wen(wen), .waddr(waddr), .wdata(wdata),
    .pending_count(pending_count), .err(err)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // advance one edge and settle away from it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic issue(input logic [4:0] a);
    md_issue_valid = 1'b1;
    md_issue_waddr = a;
    settle();
    check("issue_ready", md_issue_ready, 1);
    step();
    md_issue_valid = 1'b0;
  endtask

  // complete one md op and check the write it produces against the queue
  task automatic complete(input logic [31:0] d);
    logic [36:0] e;
    md_done_valid = 1'b1;
    md_done_wdata = d;
    settle();
    check("done_ready", md_done_ready, 1);
    step();
    md_done_valid = 1'b0;
    if (exp_q.size() == 0) begin
      check("exp_q_empty", 1, 0);
    end else begin
      e = exp_q.pop_front();
      check("md_wen", wen, 1);
      check("md_waddr", waddr, 32'(e[36:32]));
      check("md_wdata", wdata, e[31:0]);
    end
  endtask

  initial begin
    // reset
    repeat (2) step();
    check("rst_wen", wen, 0);
    check("rst_waddr", waddr, 0);
    check("rst_wdata", wdata, 0);
    check("rst_pending", pending_count, 0);
    check("rst_err", err, 0);
    check("rst_issue_ready", md_issue_ready, 1);
    check("rst_done_ready", md_done_ready, 0);
    check("rst_stall", stall, 0);
    rst = 1'b1;
    step();

    // 1: pipe write
    pipe_valid = 1'b1; pipe_waddr = 5'd5; pipe_wdata = 32'hDEADBEEF;
    step();
    pipe_valid = 1'b0;
    check("t1_wen", wen, 1);
    check("t1_waddr", waddr, 5);
    check("t1_wdata", wdata, 32'hDEADBEEF);
    step();
    check("t1_wen_off", wen, 0);
    check("t1_waddr_hold", waddr, 5);
    check("t1_wdata_hold", wdata, 32'hDEADBEEF);

    // 2: RAW stall and md completion
    rs_a = 5'd7;
    md_issue_valid = 1'b1; md_issue_waddr = 5'd7;
    settle();
    check("t2_stall_before", stall, 0);
    step();
    md_issue_valid = 1'b0;
    check("t2_stall", stall, 1);
    check("t2_pending1", pending_count, 1);
    exp_q.push_back({5'd7, 32'h1234});
    complete(32'h1234);
    check("t2_stall_clear", stall, 0);
    check("t2_pending0", pending_count, 0);
    rs_a = 5'd0;

    // 3: pipe and md done collide; pipe first, md next cycle
    issue(5'd9);
    issue(5'd10);
    exp_q.push_back({5'd9, 32'h9999});
    exp_q.push_back({5'd10, 32'h1010});
    pipe_valid = 1'b1; pipe_waddr = 5'd3; pipe_wdata = 32'hAAAA;
    md_done_valid = 1'b1; md_done_wdata = 32'h9999;
    settle();
    check("t3_done_blocked", md_done_ready, 0);
    step();
    pipe_valid = 1'b0;
    check("t3_pipe_wen", wen, 1);
    check("t3_pipe_waddr", waddr, 3);
    check("t3_pipe_wdata", wdata, 32'hAAAA);
    check("t3_pending_held", pending_count, 2);
    complete(32'h9999);
    complete(32'h1010);
    check("t3_pending0", pending_count, 0);

    // 4: full FIFO and WAW block
    for (int i = 1; i <= 4; i++) issue(5'(i));
    md_issue_valid = 1'b1; md_issue_waddr = 5'd5;
    settle();
    check("t4_full_ready", md_issue_ready, 0);
    check("t4_pending4", pending_count, 4);
    step();
    check("t4_no_push", pending_count, 4);
    md_issue_valid = 1'b0;
    exp_q.push_back({5'd1, 32'h11});
    complete(32'h11);
    check("t4_pending3", pending_count, 3);
    md_issue_valid = 1'b1; md_issue_waddr = 5'd2;
    settle();
    check("t4_waw_ready", md_issue_ready, 0);
    md_issue_waddr = 5'd6;
    settle();
    check("t4_free_ready", md_issue_ready, 1);
    md_issue_valid = 1'b0;
    exp_q.push_back({5'd2, 32'h22});
    exp_q.push_back({5'd3, 32'h33});
    exp_q.push_back({5'd4, 32'h44});
    complete(32'h22);
    complete(32'h33);
    complete(32'h44);
    check("t4_pending0", pending_count, 0);

    // 5: issue to r0 never writes
    issue(5'd0);
    check("t5_pending1", pending_count, 1);
    rs_a = 5'd0; rs_b = 5'd0;
    settle();
    check("t5_stall", stall, 0);
    md_done_valid = 1'b1; md_done_wdata = 32'h5555;
    step();
    md_done_valid = 1'b0;
    check("t5_wen", wen, 0);
    check("t5_pending0", pending_count, 0);

    // 6: done on empty FIFO -> sticky err, then reset mid-burst
    md_done_valid = 1'b1; md_done_wdata = 32'h6666;
    settle();
    check("t6_done_ready", md_done_ready, 0);
    step();
    md_done_valid = 1'b0;
    check("t6_err", err, 1);
    check("t6_wen", wen, 0);
    step();
    check("t6_err_sticky", err, 1);
    issue(5'd11);
    issue(5'd12);
    pipe_valid = 1'b1; pipe_waddr = 5'd20; pipe_wdata = 32'hCAFE;
    issue(5'd13);
    pipe_valid = 1'b0;
    rs_a = 5'd11;
    settle();
    check("t6_pending3", pending_count, 3);
    check("t6_wen_pre", wen, 1);
    check("t6_stall_pre", stall, 1);
    #1 rst = 1'b0;
    #1;
    check("t6_rst_wen", wen, 0);
    check("t6_rst_waddr", waddr, 0);
    check("t6_rst_wdata", wdata, 0);
    check("t6_rst_pending", pending_count, 0);
    check("t6_rst_err", err, 0);
    check("t6_rst_stall", stall, 0);
    check("t6_rst_ready", md_issue_ready, 1);
    step();
    rst = 1'b1;
    rs_a = 5'd0;
    // a late result after reset has no tag
    md_done_valid = 1'b1; md_done_wdata = 32'h7777;
    step();
    md_done_valid = 1'b0;
    check("t6_late_err", err, 1);
    check("t6_late_wen", wen, 0);

    // 7: pipe write to busy register proceeds, flags err
    rst = 1'b0;
    step();
    rst = 1'b1;
    step();
    issue(5'd8);
    rs_a = 5'd8;
    pipe_valid = 1'b1; pipe_waddr = 5'd8; pipe_wdata = 32'hBEEF;
    step();
    pipe_valid = 1'b0;
    check("t7_wen", wen, 1);
    check("t7_waddr", waddr, 8);
    check("t7_wdata", wdata, 32'hBEEF);
    check("t7_err", err, 1);
    check("t7_stall_kept", stall, 1);
    exp_q.push_back({5'd8, 32'h8888});
    complete(32'h8888);
    check("t7_stall_clear", stall, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/writeback_scoreboard.md
Name: writeback_scoreboard

Overview:
- Write-side initiator for the 2R/1W register file.
- Merges single-cycle pipeline results and out-of-order-timed long-latency (mul/div) results onto the one write port (wen/waddr/wdata).
- Tracks destination registers of in-flight long-latency ops in a busy bitmap and raises a decode stall on read-after-write hazards.
- Sits between the EX/MEM stage, the mul/div unit and the register file write port.

Parameters:
MD_OUTSTANDING, 4, max in-flight long-latency ops; power of two, 2..16
CNT_W, $clog2(MD_OUTSTANDING)+1, width of pending_count

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low (asserted at 0)
pipe_valid  in  1  single-cycle result valid this cycle
pipe_waddr  in  5  destination of pipe result
pipe_wdata  in  32  pipe result data
md_issue_valid  in  1  long-latency op issued
md_issue_waddr  in  5  destination of issued op
md_issue_ready  out  1  issue accepted when valid&&ready
md_done_valid  in  1  long-latency result available (in issue order)
md_done_wdata  in  32  long-latency result data
md_done_ready  out  1  result consumed when valid&&ready
rs_a  in  5  decode read address A
rs_b  in  5  decode read address B
stall  out  1  decode must hold
wen  out  1  register file write enable
waddr  out  5  register file write address
wdata  out  32  register file write data
pending_count  out  CNT_W  in-flight long-latency ops
err  out  1  sticky protocol error

Behaviour:
- Reset (rst=0, async): wen=0, waddr=0, wdata=0, busy=0, addr FIFO empty, pending_count=0, err=0. Combinational outputs then read md_issue_ready=1 (when FIFO empty) and stall=0. Reset mid-operation discards all in-flight tags; a later md_done_valid is treated as an error.
- Addr FIFO: depth MD_OUTSTANDING, holds issued destinations in order. Push on md_issue_valid&&md_issue_ready. Pop on md_done_valid&&md_done_ready.
- md_issue_ready (combinational) = !full && !(md_issue_waddr!=0 && busy[md_issue_waddr]). This blocks WAW. A pop in the same cycle does not make room: ready uses the current full flag.
- Issue to r0: accepted and pushed to keep ordering; busy is not set; the completion never writes.
- Arbitration: pipe has strict priority. md_done_ready = !pipe_valid && !empty. Both are combinational.
- Write port is registered, 1-cycle latency. At the edge after:
  - An accepted pipe result: wen=(pipe_waddr!=0), waddr=pipe_waddr, wdata=pipe_wdata.
  - An accepted md result: wen=(head!=0), waddr=head, wdata=md_done_wdata.
  - Neither: wen=0; waddr and wdata hold their values.
- Busy bitmap (32 bits, bit 0 constant 0):
  - Set on the push edge.
  - Cleared on the edge that registers the md write, so busy drops in the same cycle wen is high.
  - The register file's write forwarding then supplies the value to decode.
  - Set and clear never coincide on one address, because issue_ready blocks it.
- stall (combinational) = (rs_a!=0 && busy[rs_a]) || (rs_b!=0 && busy[rs_b]).
- pipe_valid to a busy register: the write proceeds, busy is unchanged, and err is set.
- md_done_valid while FIFO empty: ignored, and err is set. err clears only on reset.
- pending_count = FIFO occupancy. It is unchanged on a simultaneous push and pop.

Test Plan:
- Reset then pipe_valid waddr=5 wdata=0xDEADBEEF for 1 cycle -> next cycle wen=1 waddr=5 wdata=0xDEADBEEF; following cycle wen=0.
- Issue md waddr=7, rs_a=7 -> stall=1 from the cycle after issue. md_done 0x1234 with pipe idle -> next cycle wen=1 waddr=7 wdata=0x1234 and stall=0 in that same cycle. pending_count goes 1->0.
- pipe_valid and md_done_valid in the same cycle -> md_done_ready=0, pipe write lands first; md write follows next cycle in order.
- Issue 4 ops to r1..r4 -> md_issue_ready=0 on the 5th, pending_count=4. Issue to r2 while busy -> ready=0 even when not full.
- Issue to r0, then complete -> wen stays 0, busy unchanged, stall=0 with rs_a=0.
- md_done_valid with empty FIFO -> err=1 sticky, no write. Then rst=0 mid-burst with 3 pending -> all outputs reset immediately and pending_count=0.
